// File: rtl/output_port_allocator.sv
// Output-port allocator: round-robin across inputs, locks the output to one input for a whole packet, credit-gated.
// Latency: grant is combinational from req in the same cycle; state, pointer and credits update on the next edge.
// Backpressure: no grant while credits==0 or, when locked, while the owner has no flit; competing inputs simply wait.
module output_port_allocator #(
    parameter int N          = 5,
    parameter int CREDIT_MAX = 4,
    localparam int CW        = $clog2(CREDIT_MAX + 1),
    localparam int PW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  tail,
    input  logic          credit_in,
    output logic [N-1:0]  grant,
    output logic          valid_out,
    output logic [CW-1:0] credits,
    output logic          locked
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] win_idx;
    logic          win_vld;
    logic          transfer;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        int n;
        n = int'(i) + 1;
        if (n >= N) n = 0;
        return PW'(n);
    endfunction

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(idx);
            end
        end
    end

    // Reset is an asynchronous input, so it also forces grant low combinationally.
    always_comb begin
        grant = '0;
        if (reset_n && credits != '0) begin
            if (state == IDLE) begin
                if (win_vld) grant[win_idx] = 1'b1;
            end else if (req[owner]) begin
                grant[owner] = 1'b1;
            end
        end
    end

    assign transfer  = |grant;
    assign valid_out = transfer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            credits <= CW'(CREDIT_MAX);
            locked  <= 1'b0;
        end else begin
            if (transfer && !credit_in)
                credits <= credits - CW'(1);
            else if (!transfer && credit_in && credits != CW'(CREDIT_MAX))
                credits <= credits + CW'(1);

            if (transfer) begin
                if (state == IDLE) begin
                    if (tail[win_idx]) begin
                        ptr <= next_idx(win_idx);
                    end else begin
                        state  <= LOCKED;
                        owner  <= win_idx;
                        locked <= 1'b1;
                    end
                end else if (tail[owner]) begin
                    state  <= IDLE;
                    locked <= 1'b0;
                    ptr    <= next_idx(owner);
                end
            end
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator (N=5, CREDIT_MAX=4); expected per-cycle outputs are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_output_port_allocator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] req;
    logic [4:0] tail;
    logic       credit_in;
    logic [4:0] grant;
    logic       valid_out;
    logic [2:0] credits;
    logic       locked;

    typedef struct {
        logic [4:0] g;
        logic [2:0] c;
        logic       l;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    output_port_allocator #(.N(5), .CREDIT_MAX(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .tail      (tail),
        .credit_in (credit_in),
        .grant     (grant),
        .valid_out (valid_out),
        .credits   (credits),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT presents a result every cycle; compare against the oldest queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (grant !== e.g || valid_out !== (|e.g) || credits !== e.c || locked !== e.l) begin
                n_fail++;
                $display("FAIL %s: got grant=%b valid=%b credits=%0d locked=%b, want grant=%b valid=%b credits=%0d locked=%b",
                         e.nm, grant, valid_out, credits, locked, e.g, |e.g, e.c, e.l);
            end
        end
    end

    task automatic step(input string nm, input logic rn, input logic [4:0] r, input logic [4:0] t,
                        input logic ci, input logic [4:0] eg, input logic [2:0] ec, input logic el);
        @(posedge clk);
        #1;
        reset_n   = rn;
        req       = r;
        tail      = t;
        credit_in = ci;
        q.push_back('{g: eg, c: ec, l: el, nm: nm});
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = 5'b11111;
        tail      = 5'b00000;
        credit_in = 1'b0;

        //    name        rst  req       tail      cin   grant     cred  lock
        step("reset0",    0, 5'b11111, 5'b00000, 0,   5'b00000, 3'd4, 0);
        step("reset1",    0, 5'b11111, 5'b11111, 1,   5'b00000, 3'd4, 0);
        // Round-robin over single-flit packets until credits run out.
        step("rr_c1",     1, 5'b10110, 5'b11111, 0,   5'b00010, 3'd4, 0);
        step("rr_c2",     1, 5'b10110, 5'b11111, 0,   5'b00100, 3'd3, 0);
        step("rr_c3",     1, 5'b10110, 5'b11111, 0,   5'b10000, 3'd2, 0);
        step("rr_c4",     1, 5'b10110, 5'b11111, 0,   5'b00010, 3'd1, 0);
        step("rr_c5",     1, 5'b10110, 5'b11111, 0,   5'b00000, 3'd0, 0);
        // Zero credits block even with credit_in in the same cycle.
        step("cr0_blk",   1, 5'b00001, 5'b00001, 1,   5'b00000, 3'd0, 0);
        step("cr_xfer_in",1, 5'b00001, 5'b00001, 1,   5'b00001, 3'd1, 0);
        step("cr_refill1",1, 5'b00000, 5'b00000, 1,   5'b00000, 3'd1, 0);
        step("cr_refill2",1, 5'b00000, 5'b00000, 1,   5'b00000, 3'd2, 0);
        step("cr_refill3",1, 5'b00000, 5'b00000, 1,   5'b00000, 3'd3, 0);
        // Saturation at CREDIT_MAX.
        step("sat1",      1, 5'b00000, 5'b00000, 1,   5'b00000, 3'd4, 0);
        step("sat2",      1, 5'b00000, 5'b00000, 1,   5'b00000, 3'd4, 0);
        step("sat3",      1, 5'b00000, 5'b00000, 1,   5'b00000, 3'd4, 0);
        step("sat4",      1, 5'b00000, 5'b00000, 0,   5'b00000, 3'd4, 0);
        // Four-flit packet on input 0 while input 1 also requests.
        step("rst_pk",    0, 5'b00011, 5'b00000, 0,   5'b00000, 3'd4, 0);
        step("pk_f1",     1, 5'b00011, 5'b00000, 1,   5'b00001, 3'd4, 0);
        step("pk_f2",     1, 5'b00011, 5'b00000, 1,   5'b00001, 3'd4, 1);
        step("pk_f3",     1, 5'b00011, 5'b00000, 1,   5'b00001, 3'd4, 1);
        step("pk_tail",   1, 5'b00011, 5'b00001, 1,   5'b00001, 3'd4, 1);
        step("pk_next",   1, 5'b00011, 5'b00010, 1,   5'b00010, 3'd4, 0);
        // Lock on input 2 with owner bubbles while input 3 requests.
        step("lk2_head",  1, 5'b01100, 5'b00000, 0,   5'b00100, 3'd4, 0);
        step("lk2_bub1",  1, 5'b01000, 5'b00000, 0,   5'b00000, 3'd3, 1);
        step("lk2_bub2",  1, 5'b01000, 5'b01000, 0,   5'b00000, 3'd3, 1);
        step("lk2_body",  1, 5'b01100, 5'b00000, 0,   5'b00100, 3'd3, 1);
        step("lk2_tail",  1, 5'b01100, 5'b00100, 0,   5'b00100, 3'd2, 1);
        step("lk2_idle",  1, 5'b00000, 5'b00000, 1,   5'b00000, 3'd1, 0);
        // Lock on input 4 at two credits, then reset mid-cycle.
        step("lk4_head",  1, 5'b10000, 5'b00000, 1,   5'b10000, 3'd2, 0);
        step("lk4_rst",   0, 5'b10000, 5'b00000, 0,   5'b00000, 3'd4, 0);
        step("lk4_rst2",  0, 5'b11111, 5'b11111, 0,   5'b00000, 3'd4, 0);
        step("post_rst",  1, 5'b11111, 5'b11111, 0,   5'b00001, 3'd4, 0);
        step("post_rst2", 1, 5'b11111, 5'b11111, 0,   5'b00010, 3'd3, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
